// File: rtl/fbuf_pixel_fetch_pkg.sv
// -----------------------------------------------------------------------------
// fbuf_pixel_fetch_pkg
// Shared definitions for the framebuffer pixel fetch stage:
//   - pixel / RGB888 width constants and palette depth
//   - page-flip state encoding (idle / flip pending until next vblank)
//   - RGB332 -> RGB888 bit-replication expansion used when the palette
//     (FBUF_PALETTE_EN) is not built
// -----------------------------------------------------------------------------
package fbuf_pixel_fetch_pkg;

    localparam int PIX_W     = 8;
    localparam int RGB_W     = 24;
    localparam int PAL_DEPTH = 256;

    typedef enum logic [0:0] {
        FLIP_IDLE    = 1'b0,
        FLIP_PENDING = 1'b1
    } flip_state_e;

    // Expand RRRGGGBB to 8 bits per channel by replicating the MSBs so that
    // full-scale codes map to 8'hFF and zero maps to 8'h00.
    function automatic logic [RGB_W-1:0] rgb332_to_rgb888(input logic [PIX_W-1:0] pix);
        logic [7:0] r_s;
        logic [7:0] g_s;
        logic [7:0] b_s;
        r_s = {pix[7:5], pix[7:5], pix[7:6]};
        g_s = {pix[4:2], pix[4:2], pix[4:3]};
        b_s = {pix[1:0], pix[1:0], pix[1:0], pix[1:0]};
        return {r_s, g_s, b_s};
    endfunction

endpackage

// File: rtl/fbuf_palette_ram.sv
// -----------------------------------------------------------------------------
// fbuf_palette_ram
// 256 x 24 palette memory: one synchronous write port, one registered
// read-first read port. The read register doubles as the pixel output
// register of the fetch pipeline, so it is zeroed when rd_en is low
// (blanking) and on rst. Memory contents are never cleared.
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   wr_en/wr_idx/wr_rgb palette write strobe, entry index, {R,G,B}
//   rd_en/rd_idx        read enable (gates output to zero), entry index
//   rd_rgb              registered entry value
// -----------------------------------------------------------------------------
module fbuf_palette_ram
    import fbuf_pixel_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_idx,
    input  logic [RGB_W-1:0] wr_rgb,
    input  logic             rd_en,
    input  logic [7:0]       rd_idx,
    output logic [RGB_W-1:0] rd_rgb
);

    logic [RGB_W-1:0] mem_r [PAL_DEPTH];
    logic [RGB_W-1:0] rd_rgb_r;

    // Palette storage write port; no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_rgb;
        end
    end

    // Registered read; a same-cycle write to rd_idx is not yet visible
    // (read-first), because the memory update is non-blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_rgb_r <= {RGB_W{1'b0}};
        end else if (rd_en) begin
            rd_rgb_r <= mem_r[rd_idx];
        end else begin
            rd_rgb_r <= {RGB_W{1'b0}};
        end
    end

    assign rd_rgb = rd_rgb_r;

endmodule

// File: rtl/fbuf_pixel_fetch.sv
// -----------------------------------------------------------------------------
// fbuf_pixel_fetch
// Pixel fetch stage after the framebuffer timing generator: computes the
// BRAM address for the active page, reads the pixel, converts it to RGB888
// and keeps hsync/vsync/vde aligned with the pixel (latency 2+BRAM_LATENCY).
// Page flips requested with flip_req are applied on the next rising edge of
// in_eof (start of vertical blanking), so a page never changes mid-frame.
//
// Build option: define FBUF_PALETTE_EN to map pixels through a writable
// 256-entry palette; otherwise pixels are RGB332 expanded by bit replication
// and the pal_wr_* inputs are ignored.
//
// Ports:
//   clk, rst                    pixel clock, synchronous active-high reset
//   in_vde/in_hsync/in_vsync    timing from the generator
//   in_eof                      end of frame, rising edge = vblank start
//   in_fbuf_address             page-relative pixel address
//   bram_en, bram_addr          BRAM read request (registered)
//   bram_dout                   BRAM data, BRAM_LATENCY cycles after address
//   pal_wr_en/idx/rgb           palette write port
//   flip_req, flip_ack          page flip request / one-cycle apply pulse
//   active_page                 page currently scanned out
//   vid_pdata, vid_vde/hsync/vsync  aligned RGB888 output to DVI encoder
// -----------------------------------------------------------------------------
module fbuf_pixel_fetch
    import fbuf_pixel_fetch_pkg::*;
#(
    parameter int          FBUF_ADDR_WIDTH = 19,
    parameter int          PIXEL_WIDTH     = 8,
    parameter int          BRAM_LATENCY    = 2,
    parameter int unsigned PAGE_OFFSET     = 76800
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vde,
    input  logic                       in_hsync,
    input  logic                       in_vsync,
    input  logic                       in_eof,
    input  logic [FBUF_ADDR_WIDTH-1:0] in_fbuf_address,
    output logic                       bram_en,
    output logic [FBUF_ADDR_WIDTH-1:0] bram_addr,
    input  logic [PIXEL_WIDTH-1:0]     bram_dout,
    input  logic                       pal_wr_en,
    input  logic [7:0]                 pal_wr_idx,
    input  logic [RGB_W-1:0]           pal_wr_rgb,
    input  logic                       flip_req,
    output logic                       flip_ack,
    output logic                       active_page,
    output logic [RGB_W-1:0]           vid_pdata,
    output logic                       vid_vde,
    output logic                       vid_hsync,
    output logic                       vid_vsync
);

    localparam int CTRL_DEPTH = 2 + BRAM_LATENCY;
    localparam logic [FBUF_ADDR_WIDTH-1:0] PAGE_OFFSET_A = FBUF_ADDR_WIDTH'(PAGE_OFFSET);

    // ---------------- page flip FSM ----------------
    flip_state_e flip_state_r;
    flip_state_e flip_state_s;
    logic        eof_prev_r;
    logic        eof_rise_s;
    logic        flip_apply_s;
    logic        active_page_r;
    logic        flip_ack_r;

    // Next-state logic: a request taken in the same cycle as the eof edge
    // is applied immediately; further requests while pending are dropped.
    always_comb begin
        eof_rise_s   = in_eof & ~eof_prev_r;
        flip_apply_s = 1'b0;
        flip_state_s = flip_state_r;
        case (flip_state_r)
            FLIP_IDLE: begin
                if (flip_req && eof_rise_s) begin
                    flip_apply_s = 1'b1;
                    flip_state_s = FLIP_IDLE;
                end else if (flip_req) begin
                    flip_state_s = FLIP_PENDING;
                end else begin
                    flip_state_s = FLIP_IDLE;
                end
            end
            FLIP_PENDING: begin
                if (eof_rise_s) begin
                    flip_apply_s = 1'b1;
                    flip_state_s = FLIP_IDLE;
                end else begin
                    flip_state_s = FLIP_PENDING;
                end
            end
            default: begin
                flip_state_s = FLIP_IDLE;
            end
        endcase
    end

    // FSM state, eof edge history, page select and acknowledge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            flip_state_r  <= FLIP_IDLE;
            eof_prev_r    <= 1'b0;
            active_page_r <= 1'b0;
            flip_ack_r    <= 1'b0;
        end else begin
            flip_state_r <= flip_state_s;
            eof_prev_r   <= in_eof;
            flip_ack_r   <= flip_apply_s;
            if (flip_apply_s) begin
                active_page_r <= ~active_page_r;
            end else begin
                active_page_r <= active_page_r;
            end
        end
    end

    assign active_page = active_page_r;
    assign flip_ack    = flip_ack_r;

    // ---------------- stage A: address ----------------
    logic [FBUF_ADDR_WIDTH-1:0] page_base_s;
    logic [FBUF_ADDR_WIDTH-1:0] bram_addr_r;
    logic                       bram_en_r;

    // Page base for the current page; the sum below wraps at the address width.
    always_comb begin
        if (active_page_r) begin
            page_base_s = PAGE_OFFSET_A;
        end else begin
            page_base_s = {FBUF_ADDR_WIDTH{1'b0}};
        end
    end

    // Registered BRAM request.
    always_ff @(posedge clk) begin
        if (rst) begin
            bram_addr_r <= {FBUF_ADDR_WIDTH{1'b0}};
            bram_en_r   <= 1'b0;
        end else begin
            bram_addr_r <= in_fbuf_address + page_base_s;
            bram_en_r   <= in_vde;
        end
    end

    assign bram_addr = bram_addr_r;
    assign bram_en   = bram_en_r;

    // ---------------- control delay line ----------------
    // Each entry is {vde, hsync, vsync}; entry i holds inputs from i+1 cycles ago.
    logic [CTRL_DEPTH-1:0][2:0] ctrl_sr_r;
    logic                       vde_c_s;

    // Shift the video control signals alongside the pixel pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_sr_r <= {(CTRL_DEPTH*3){1'b0}};
        end else begin
            ctrl_sr_r <= {ctrl_sr_r[CTRL_DEPTH-2:0], in_vde, in_hsync, in_vsync};
        end
    end

    // vde as seen at the input of stage C, aligned with bram_dout.
    assign vde_c_s   = ctrl_sr_r[BRAM_LATENCY][2];
    assign vid_vde   = ctrl_sr_r[CTRL_DEPTH-1][2];
    assign vid_hsync = ctrl_sr_r[CTRL_DEPTH-1][1];
    assign vid_vsync = ctrl_sr_r[CTRL_DEPTH-1][0];

    // ---------------- stage C: colour conversion ----------------
`ifdef FBUF_PALETTE_EN
    fbuf_palette_ram u_palette (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (pal_wr_en),
        .wr_idx (pal_wr_idx),
        .wr_rgb (pal_wr_rgb),
        .rd_en  (vde_c_s),
        .rd_idx (bram_dout[PIX_W-1:0]),
        .rd_rgb (vid_pdata)
    );
`else
    logic [RGB_W-1:0] vid_pdata_r;
    logic             unused_pal_s;

    // RGB332 expansion, forced to black outside active video.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid_pdata_r <= {RGB_W{1'b0}};
        end else if (vde_c_s) begin
            vid_pdata_r <= rgb332_to_rgb888(bram_dout[PIX_W-1:0]);
        end else begin
            vid_pdata_r <= {RGB_W{1'b0}};
        end
    end

    assign vid_pdata    = vid_pdata_r;
    assign unused_pal_s = ^{pal_wr_en, pal_wr_idx, pal_wr_rgb};
`endif

endmodule

// File: tb/tb_fbuf_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_fbuf_pixel_fetch
// Directed bench for fbuf_pixel_fetch with default parameters
// (BRAM_LATENCY=2). The BRAM model returns the low 8 address bits two cycles
// after the address. Expected pixels depend on FBUF_PALETTE_EN.
// -----------------------------------------------------------------------------
module tb_fbuf_pixel_fetch;

    logic        clk;
    logic        rst;
    logic        in_vde;
    logic        in_hsync;
    logic        in_vsync;
    logic        in_eof;
    logic [18:0] in_fbuf_address;
    logic        bram_en;
    logic [18:0] bram_addr;
    logic [7:0]  bram_dout;
    logic        pal_wr_en;
    logic [7:0]  pal_wr_idx;
    logic [23:0] pal_wr_rgb;
    logic        flip_req;
    logic        flip_ack;
    logic        active_page;
    logic [23:0] vid_pdata;
    logic        vid_vde;
    logic        vid_hsync;
    logic        vid_vsync;

    logic [7:0]  bram_q1_r;
    logic [7:0]  bram_q2_r;

    int vec_cnt;
    int err_cnt;

`ifdef FBUF_PALETTE_EN
    localparam logic [23:0] EXP_P05    = 24'h123456;
    localparam logic [23:0] EXP_PE3    = 24'h0A0B0C;
    localparam logic [23:0] EXP_P1C    = 24'h0D0E0F;
    localparam logic [23:0] EXP_P03    = 24'h333333;
    localparam logic [23:0] EXP_RF_OLD = 24'h111111;
    localparam logic [23:0] EXP_RF_NEW = 24'h222222;
`else
    localparam logic [23:0] EXP_P05    = 24'h002455;
    localparam logic [23:0] EXP_PE3    = 24'hFF00FF;
    localparam logic [23:0] EXP_P1C    = 24'h00FF00;
    localparam logic [23:0] EXP_P03    = 24'h0000FF;
    localparam logic [23:0] EXP_RF_OLD = 24'h004955;
    localparam logic [23:0] EXP_RF_NEW = 24'h004955;
`endif

    fbuf_pixel_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .in_vde          (in_vde),
        .in_hsync        (in_hsync),
        .in_vsync        (in_vsync),
        .in_eof          (in_eof),
        .in_fbuf_address (in_fbuf_address),
        .bram_en         (bram_en),
        .bram_addr       (bram_addr),
        .bram_dout       (bram_dout),
        .pal_wr_en       (pal_wr_en),
        .pal_wr_idx      (pal_wr_idx),
        .pal_wr_rgb      (pal_wr_rgb),
        .flip_req        (flip_req),
        .flip_ack        (flip_ack),
        .active_page     (active_page),
        .vid_pdata       (vid_pdata),
        .vid_vde         (vid_vde),
        .vid_hsync       (vid_hsync),
        .vid_vsync       (vid_vsync)
    );

    // Pixel clock, 10 time units.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-cycle BRAM model returning the address LSBs as pixel data.
    always @(posedge clk) begin
        bram_q1_r <= bram_addr[7:0];
        bram_q2_r <= bram_q1_r;
    end
    assign bram_dout = bram_q2_r;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: across the rising edge, then sample/drive on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pal_write(input logic [7:0] idx, input logic [23:0] rgb);
        pal_wr_en  = 1'b1;
        pal_wr_idx = idx;
        pal_wr_rgb = rgb;
        step();
        pal_wr_en  = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check_vec({pfx, "_bram_en"},     {31'd0, bram_en},     32'd0);
        check_vec({pfx, "_bram_addr"},   {13'd0, bram_addr},   32'd0);
        check_vec({pfx, "_vid_pdata"},   {8'd0, vid_pdata},    32'd0);
        check_vec({pfx, "_vid_vde"},     {31'd0, vid_vde},     32'd0);
        check_vec({pfx, "_vid_hsync"},   {31'd0, vid_hsync},   32'd0);
        check_vec({pfx, "_vid_vsync"},   {31'd0, vid_vsync},   32'd0);
        check_vec({pfx, "_flip_ack"},    {31'd0, flip_ack},    32'd0);
        check_vec({pfx, "_active_page"}, {31'd0, active_page}, 32'd0);
    endtask

    initial begin
        vec_cnt         = 0;
        err_cnt         = 0;
        rst             = 1'b1;
        in_vde          = 1'b0;
        in_hsync        = 1'b0;
        in_vsync        = 1'b0;
        in_eof          = 1'b0;
        in_fbuf_address = 19'd0;
        pal_wr_en       = 1'b0;
        pal_wr_idx      = 8'd0;
        pal_wr_rgb      = 24'd0;
        flip_req        = 1'b0;
        @(negedge clk);
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;

`ifdef FBUF_PALETTE_EN
        pal_write(8'h05, 24'h123456);
        pal_write(8'hE3, 24'h0A0B0C);
        pal_write(8'h1C, 24'h0D0E0F);
        pal_write(8'h03, 24'h333333);
        pal_write(8'h09, 24'h111111);
`endif
        step();
        step();

        // Latency: one active pixel with an hsync pulse.
        in_vde = 1'b1; in_hsync = 1'b1; in_fbuf_address = 19'd5;
        step();
        check_vec("lat_bram_en",   {31'd0, bram_en},   32'd1);
        check_vec("lat_bram_addr", {13'd0, bram_addr}, 32'd5);
        in_vde = 1'b0; in_hsync = 1'b0; in_fbuf_address = 19'd0;
        step();
        step();
        check_vec("lat_early_vde", {31'd0, vid_vde}, 32'd0);
        step();
        check_vec("lat_vde",   {31'd0, vid_vde},   32'd1);
        check_vec("lat_hsync", {31'd0, vid_hsync}, 32'd1);
        check_vec("lat_pdata", {8'd0, vid_pdata},  {8'd0, EXP_P05});
        step();
        check_vec("lat_vde_end",   {31'd0, vid_vde},   32'd0);
        check_vec("lat_hsync_end", {31'd0, vid_hsync}, 32'd0);
        check_vec("lat_pdata_end", {8'd0, vid_pdata},  32'd0);

        // Two back-to-back pixels with vsync held.
        in_vde = 1'b1; in_vsync = 1'b1; in_fbuf_address = 19'h000E3;
        step();
        in_fbuf_address = 19'h0001C;
        step();
        in_vde = 1'b0; in_vsync = 1'b0; in_fbuf_address = 19'd0;
        step();
        step();
        check_vec("pix_e3",    {8'd0, vid_pdata},  {8'd0, EXP_PE3});
        check_vec("pix_vsync", {31'd0, vid_vsync}, 32'd1);
        step();
        check_vec("pix_1c", {8'd0, vid_pdata}, {8'd0, EXP_P1C});

        // Blanking with nonzero BRAM data.
        in_vde = 1'b0; in_fbuf_address = 19'h000AB;
        step();
        check_vec("blank_bram_en",   {31'd0, bram_en},   32'd0);
        check_vec("blank_bram_addr", {13'd0, bram_addr}, 32'h000AB);
        step();
        step();
        step();
        check_vec("blank_pdata", {8'd0, vid_pdata}, 32'd0);
        check_vec("blank_vde",   {31'd0, vid_vde},  32'd0);

        // Page flip: request in active video, repeated while pending.
        in_vde = 1'b1; in_fbuf_address = 19'd100; flip_req = 1'b1;
        step();
        flip_req = 1'b1;
        check_vec("flip_pend_page", {31'd0, active_page}, 32'd0);
        check_vec("flip_pend_ack",  {31'd0, flip_ack},    32'd0);
        step();
        flip_req = 1'b0; in_eof = 1'b1; in_vde = 1'b0;
        step();
        check_vec("flip_page", {31'd0, active_page}, 32'd1);
        check_vec("flip_ack",  {31'd0, flip_ack},    32'd1);
        in_fbuf_address = 19'd0; in_vde = 1'b1;
        step();
        check_vec("flip_addr",     {13'd0, bram_addr}, 32'd76800);
        check_vec("flip_ack_once", {31'd0, flip_ack},  32'd0);
        in_eof = 1'b0;
        step();
        in_eof = 1'b1;
        step();
        check_vec("flip_no_second",     {31'd0, active_page}, 32'd1);
        check_vec("flip_no_second_ack", {31'd0, flip_ack},    32'd0);

        // Request coincident with the eof rising edge.
        in_eof = 1'b0;
        step();
        flip_req = 1'b1; in_eof = 1'b1;
        step();
        flip_req = 1'b0;
        check_vec("simul_page", {31'd0, active_page}, 32'd0);
        check_vec("simul_ack",  {31'd0, flip_ack},    32'd1);
        step();
        check_vec("simul_ack_end", {31'd0, flip_ack}, 32'd0);
        in_vde = 1'b0; in_eof = 1'b0;
        step();
        step();
        step();
        step();

        // Palette write to index 9 in the cycle index 9 is read.
        in_vde = 1'b1; in_fbuf_address = 19'd9;
        step();
        step();
        in_vde = 1'b0; in_fbuf_address = 19'd0;
        step();
        pal_wr_en = 1'b1; pal_wr_idx = 8'h09; pal_wr_rgb = 24'h222222;
        step();
        pal_wr_en = 1'b0;
        check_vec("rf_old", {8'd0, vid_pdata}, {8'd0, EXP_RF_OLD});
        step();
        check_vec("rf_new", {8'd0, vid_pdata}, {8'd0, EXP_RF_NEW});

        // Reset mid-frame while a flip is pending.
        flip_req = 1'b1;
        step();
        flip_req = 1'b0;
        in_vde = 1'b1; in_hsync = 1'b1; in_vsync = 1'b1; in_fbuf_address = 19'd3;
        step();
        step();
        step();
        step();
        check_vec("rst_pre_vde", {31'd0, vid_vde}, 32'd1);
        rst = 1'b1;
        step();
        check_all_zero("rst_mid");
        rst = 1'b0; in_eof = 1'b1;
        step();
        check_vec("rst_drop_page", {31'd0, active_page}, 32'd0);
        check_vec("rst_drop_ack",  {31'd0, flip_ack},    32'd0);
        step();
        check_vec("rst_drop_ack2", {31'd0, flip_ack}, 32'd0);
        step();
        check_vec("rst_refill_vde", {31'd0, vid_vde}, 32'd0);
        step();
        check_vec("rst_refilled_vde",   {31'd0, vid_vde},  32'd1);
        check_vec("rst_refilled_pdata", {8'd0, vid_pdata}, {8'd0, EXP_P03});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
